// File: rtl/packet_arbiter_mux_pkg.sv
// Shared types for the router output-port arbiter: AXI-Stream channel
// structs, the routing-header TID code and the arbiter state encoding.
// TDEST/TUSER fields are compiled in with TDEST_PRESENT / TUSER_PRESENT.
package packet_arbiter_mux_pkg;

    localparam int AXIS_DATA_WIDTH = 40;
    localparam int ID_WIDTH        = 4;
    localparam int DEST_WIDTH      = 4;
    localparam int USER_WIDTH      = 4;

    // TID value that marks the first flit of a packet; arbitration keys on
    // it, so TID is always carried.
    localparam logic [ID_WIDTH-1:0] ROUTING_HEADER = 4'hA;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] TDATA;
        logic [ID_WIDTH-1:0]        TID;
`ifdef TDEST_PRESENT
        logic [DEST_WIDTH-1:0]      TDEST;
`endif
`ifdef TUSER_PRESENT
        logic [USER_WIDTH-1:0]      TUSER;
`endif
        logic                       TLAST;
    } axis_data_t;

    typedef struct packed {
        logic       TVALID;
        axis_data_t data;
    } axis_mosi_t;

    typedef struct packed {
        logic TREADY;
    } axis_miso_t;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/packet_arbiter_mux_rr_priority_picker.sv
// Combinational round-robin picker: returns the first requester found when
// scanning upward from last_grant+1, wrapping modulo N. Shared by all
// router output ports.
module rr_priority_picker
    import packet_arbiter_mux_pkg::*;
#(
    parameter int N = 5,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last_grant,
    output logic         o_valid,
    output logic [W-1:0] o_winner
);

    int w_idx;

    // Scan from the farthest candidate back to the nearest so the nearest
    // requester after last_grant is the final (winning) assignment.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(i_last_grant) + k) % N;
            if (i_req[w_idx]) begin
                o_valid  = 1'b1;
                o_winner = W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/packet_arbiter_mux.sv
// Packet-granular round-robin merge of INPUT_NUMBER AXI-Stream sources onto
// one router output port. A grant is won by a ROUTING_HEADER flit and held
// until the TLAST handshake, so packets never interleave.
// Handshake: a flit moves on a cycle where TVALID && TREADY; a source holds
// its flit stable while TVALID is high and TREADY is low.
// Optional build macro ARB_PMU_EN adds packet/flit/stall counters.
module packet_arbiter_mux
    import packet_arbiter_mux_pkg::*;
#(
    parameter int INPUT_NUMBER       = 5,
    parameter int INPUT_NUMBER_WIDTH = $clog2(INPUT_NUMBER)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  axis_mosi_t                    in_mosi_i [INPUT_NUMBER],
    output axis_miso_t                    in_miso_o [INPUT_NUMBER],
    output axis_mosi_t                    out_mosi_o,
    input  axis_miso_t                    out_miso_i,
    output logic [INPUT_NUMBER_WIDTH-1:0] grant_o,
`ifdef ARB_PMU_EN
    output logic [31:0]                   pkt_cnt_o,
    output logic [31:0]                   flit_cnt_o,
    output logic [31:0]                   stall_cnt_o,
`endif
    output logic                          locked_o
);

    arb_state_t                    r_state;
    arb_state_t                    w_state_next;
    logic [INPUT_NUMBER_WIDTH-1:0] r_grant;
    logic [INPUT_NUMBER_WIDTH-1:0] w_grant_next;
    logic [INPUT_NUMBER_WIDTH-1:0] r_last_grant;
    logic [INPUT_NUMBER_WIDTH-1:0] w_last_grant_next;
    logic [INPUT_NUMBER-1:0]       w_req;
    logic                          w_pick_valid;
    logic [INPUT_NUMBER_WIDTH-1:0] w_pick_idx;
    logic                          w_sel_valid;
    logic [INPUT_NUMBER_WIDTH-1:0] w_sel_idx;
    logic                          w_hs;

    // Only a valid header flit can request the output.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < INPUT_NUMBER; i++) begin
            w_req[i] = in_mosi_i[i].TVALID && (in_mosi_i[i].data.TID == ROUTING_HEADER);
        end
    end

    rr_priority_picker #(
        .N (INPUT_NUMBER),
        .W (INPUT_NUMBER_WIDTH)
    ) u_picker (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_pick_valid),
        .o_winner     (w_pick_idx)
    );

    // Selected source: live picker result while idle, held grant while locked.
    always_comb begin
        w_sel_valid = w_pick_valid;
        w_sel_idx   = w_pick_idx;
        if (r_state == ARB_LOCKED) begin
            w_sel_valid = 1'b1;
            w_sel_idx   = r_grant;
        end
    end

    // Forward the selected stream; everything is zeroed while in reset.
    always_comb begin
        out_mosi_o = '0;
        if (rst_n_i && w_sel_valid) begin
            out_mosi_o = in_mosi_i[w_sel_idx];
        end
    end

    // Route downstream TREADY back to the selected source only.
    always_comb begin
        for (int i = 0; i < INPUT_NUMBER; i++) begin
            in_miso_o[i] = '0;
            if (rst_n_i && w_sel_valid && (w_sel_idx == INPUT_NUMBER_WIDTH'(i))) begin
                in_miso_o[i] = out_miso_i;
            end
        end
    end

    assign w_hs     = out_mosi_o.TVALID && out_miso_i.TREADY;
    assign grant_o  = w_sel_idx;
    assign locked_o = (r_state == ARB_LOCKED);

    // Next-state: lock on a multi-flit header handshake, release on TLAST.
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        case (r_state)
            ARB_IDLE: begin
                if (w_hs) begin
                    w_last_grant_next = w_pick_idx;
                    if (!out_mosi_o.data.TLAST) begin
                        w_state_next = ARB_LOCKED;
                        w_grant_next = w_pick_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                if (w_hs && out_mosi_o.data.TLAST) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    // State registers; last_grant resets to the top index so input 0 goes first.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_last_grant <= INPUT_NUMBER_WIDTH'(INPUT_NUMBER - 1);
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
        end
    end

`ifdef ARB_PMU_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_flit_cnt;
    logic [31:0] r_stall_cnt;

    // Free-running wrap-around performance counters on the merged output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pkt_cnt   <= '0;
            r_flit_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_hs && out_mosi_o.data.TLAST) r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if (w_hs) r_flit_cnt <= r_flit_cnt + 32'd1;
            if (out_mosi_o.TVALID && !out_miso_i.TREADY) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign pkt_cnt_o   = r_pkt_cnt;
    assign flit_cnt_o  = r_flit_cnt;
    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
